instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the instruction ROM: owns the PC, drives the ROM byte address,
//  captures the returned word into a small prefetch FIFO and hands {pc, instr} to decode over a
//  valid/ready handshake. Branch/jump redirects from execute flush the FIFO and reload the PC.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset (word aligned)
//  FIFO_DEPTH 2              prefetch entries, power of two, >=2
//  ROM_WORDS  62             instruction words implemented in ROM (used only by IFU_BOUND_CHECK_EN)
// PORTS
//  clk            in   1   system clock, all state on rising edge
//  reset          in   1   asynchronous, active-high; clears all state immediately
//  imem_addr      out  32  byte address to ROM (ROM indexes addr[31:2], combinational read)
//  imem_data      in   32  instruction word returned by ROM in the same cycle
//  redirect_valid in   1   execute requests PC change (taken branch/jal/jalr)
//  redirect_pc    in   32  redirect target; bits [1:0] forced to 0
//  out_valid      out  1   FIFO head holds a valid instruction
//  out_ready      in   1   decode accepts head this cycle
//  out_instr      out  32  instruction at FIFO head
//  out_pc         out  32  PC of out_instr
//  fetch_fault    out  1   head came from out-of-range PC (IFU_BOUND_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, FIFO empty (count=0, pointers=0), out_valid=0, out_instr=0, out_pc=0, fetch_fault=0.
//  - imem_addr = pc continuously (combinational from pc register); no registered ROM read.
//  - pop  = out_valid & out_ready.
//  - push = ~redirect_valid & (count<FIFO_DEPTH | pop): write {pc, imem_data}, pc <= pc+4.
//    Full FIFO with simultaneous pop: push and pop both occur, count unchanged.
//  - redirect_valid (highest priority): FIFO flushed (count=0), pc <= {redirect_pc[31:2],2'b00},
//    no push, any pop that cycle is discarded (decode must ignore it, no side effects).
//  - Latency: redirect at edge N -> target word fetched/pushed at edge N+1 -> out_valid=1 after N+1.
//    Steady state with out_ready=1: one instruction per cycle, out_pc increments by 4 each cycle.
//  - out_valid = (count!=0); out_instr/out_pc/fetch_fault are FIFO head fields, stable while
//    out_valid & ~out_ready (handshake contract: head never changes until popped or flushed).
//  - PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no fault flagged by wrap itself.
//  - Reset asserted mid-operation: all state cleared asynchronously; fetch resumes at RESET_PC
//    on the first edge after reset deasserts.
//  - No state machine beyond FIFO count; stall is expressed solely by out_ready / full FIFO.
// CONFIGURATION
//  IFU_BOUND_CHECK_EN defined: if pc[31:2] >= ROM_WORDS the pushed instr is NOP_INSTR (addi x0,x0,0,
//    32'h0000_0013) and entry fault bit=1; fetch_fault mirrors head fault bit; pc still advances.
//  Undefined: imem_data pushed unconditionally, fault bit absent, fetch_fault tied 0.
// STRUCTURE
//  ifu_pkg: NOP_INSTR constant, fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr; logic fault;}.
//  Sub-module ifu_fifo: synchronous FIFO of fetch_entry_t, DEPTH param, push/pop/flush, count,
//    full/empty, async active-high reset; flush dominates push/pop.
//  Top holds PC register, push/redirect logic and optional bound check.
// TESTING
//  1 Reset, out_ready=1, ROM word k = k: out_valid from cycle 1, out_pc 0,4,8.., out_instr 0,1,2.. one/cycle.
//  2 out_ready=0 for 5 cycles: FIFO fills to FIFO_DEPTH, pc stops at RESET_PC+4*DEPTH, head stable;
//    release -> PCs continue in order with no gap or duplicate.
//  3 redirect_valid with redirect_pc=32'h0000_0026 while FIFO full and out_ready=1: next out_pc=32'h24,
//    stale entries never appear, out_valid low exactly one cycle.
//  4 Force pc to 32'hFFFF_FFFC via redirect: out_pc sequence FFFF_FFFC then 0000_0000.
//  5 Assert reset mid-stream (async, between edges): out_valid drops immediately, restart at RESET_PC.
//  6 IFU_BOUND_CHECK_EN, redirect to 4*ROM_WORDS: out_instr=32'h0000_0013, fetch_fault=1; redirect to 0 -> fault=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: IFU_BOUND_CHECK_EN (see instr_fetch_unit.sv).
package ifu_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    // Sequential PC step; wraps modulo 2^32.
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of fetch entries. Flush dominates push and pop; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop, wr_en;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy, flush taking priority.
    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_en    = do_push & ~flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational ROM at imem_addr = pc and
// queues {pc, instr} for decode. Redirects flush the queue and reload the PC.
// Optional feature macro: IFU_BOUND_CHECK_EN -- fetches beyond ROM_WORDS
// push NOP_INSTR with the fault bit set.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ROM_WORDS  = 62
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    logic [31:0]  pc_q, pc_d;
    logic         push, pop;
    logic         fifo_full, fifo_empty;
    fetch_entry_t entry, head;

    assign imem_addr = pc_q;
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign push      = ~redirect_valid & (~fifo_full | pop);

    // Build the entry captured from the ROM this cycle.
    always_comb begin
        entry.pc    = pc_q;
        entry.instr = imem_data;
        entry.fault = 1'b0;
`ifdef IFU_BOUND_CHECK_EN
        if ({2'b00, pc_q[31:2]} >= ROM_WORDS) begin
            entry.instr = NOP_INSTR;
            entry.fault = 1'b1;
        end
`endif
    end

    // PC next-state: redirect wins, otherwise advance on every accepted push.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            pc_d = pc_step(pc_q);
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_instr   = head.instr;
    assign out_pc      = head.pc;
    // Without the bound check every stored fault bit is zero, so this is a tie-off.
    assign fetch_fault = head.fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a vector table for the basic
// stream/stall/redirect sequence, hand sequences for wrap, async reset and the
// optional bound check, then random traffic against a queue-based model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned ROMW     = 62;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_bad = 0;

    // ROM model: word k holds k.
    assign imem_data = {2'b00, imem_addr[31:2]};

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH),
        .ROM_WORDS  (ROMW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;

    function automatic ent_t fetch_of(input logic [31:0] a);
        ent_t e;
        e.pc    = a;
        e.instr = a >> 2;
        e.fault = 1'b0;
`ifdef IFU_BOUND_CHECK_EN
        if ((a >> 2) >= ROMW) begin
            e.instr = NOP;
            e.fault = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc = RESET_PC;
    endtask

    // One clock edge of the fetch rules: redirect flushes, else pop then refill.
    task automatic model_edge(input logic rv, input logic [31:0] rp, input logic rd);
        if (rv) begin
            mq.delete();
            mpc = {rp[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && rd) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back(fetch_of(mpc));
                mpc = mpc + 32'd4;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, " valid"}, {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
        check({tag, " addr"}, imem_addr, mpc);
        if (mq.size() != 0) begin
            check({tag, " pc"}, out_pc, mq[0].pc);
            check({tag, " instr"}, out_instr, mq[0].instr);
            check({tag, " fault"}, {31'd0, fetch_fault}, {31'd0, mq[0].fault});
        end
    endtask

    // Drive inputs, take one edge, advance the model and sample 1 time unit later.
    task automatic cycle(input logic rv, input logic [31:0] rp, input logic rd);
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rd;
        @(posedge clk);
        model_edge(rv, rp, rd);
        #1;
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rp;
        logic        rd;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Stream, stall with full FIFO, release, redirect to 0x26 while full.
        vecs[0]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h00, 32'h0, 32'h04};
        vecs[1]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h04, 32'h1, 32'h08};
        vecs[2]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h08, 32'h2, 32'h0C};
        vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 32'h2, 32'h10};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 32'h2, 32'h10};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 32'h2, 32'h10};
        vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 32'h2, 32'h10};
        vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h08, 32'h2, 32'h10};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h0C, 32'h3, 32'h14};
        vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 32'h4, 32'h18};
        vecs[10] = '{1'b1, 32'h26, 1'b1, 1'b0, 32'h00, 32'h0, 32'h24};
        vecs[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h24, 32'h9, 32'h28};
        vecs[12] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h28, 32'hA, 32'h2C};

        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        reset          = 1'b1;
        model_reset();
        #12;
        check("reset valid", {31'd0, out_valid}, 32'd0);
        check("reset pc", out_pc, 32'h0);
        check("reset instr", out_instr, 32'h0);
        check("reset fault", {31'd0, fetch_fault}, 32'd0);
        check("reset addr", imem_addr, RESET_PC);
        reset = 1'b0;

        // Table-driven sequence.
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].rv, vecs[i].rp, vecs[i].rd);
            check($sformatf("vec%0d valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("vec%0d addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("vec%0d fault", i), {31'd0, fetch_fault}, 32'd0);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d pc", i), out_pc, vecs[i].e_pc);
                check($sformatf("vec%0d instr", i), out_instr, vecs[i].e_instr);
            end
        end

        // PC wrap through 2^32.
        cycle(1'b1, 32'hFFFF_FFFE, 1'b1);
        model_check("wrap0");
        cycle(1'b0, 32'h0, 1'b1);
        check("wrap pc hi", out_pc, 32'hFFFF_FFFC);
        model_check("wrap1");
        cycle(1'b0, 32'h0, 1'b1);
        check("wrap pc lo", out_pc, 32'h0000_0000);
        check("wrap fault", {31'd0, fetch_fault}, 32'd0);
        model_check("wrap2");

        // Async reset asserted between edges while the FIFO holds data.
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("areset valid", {31'd0, out_valid}, 32'd0);
        check("areset addr", imem_addr, RESET_PC);
        check("areset pc", out_pc, 32'h0);
        check("areset instr", out_instr, 32'h0);
        #2;
        reset = 1'b0;

        // Fill from reset with decode stalled: PC parks at RESET_PC + 4*DEPTH.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            model_check("fill");
            check("fill head", out_pc, RESET_PC);
        end
        check("fill park", imem_addr, RESET_PC + 4 * DEPTH);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            check("drain order", out_pc, RESET_PC + 4 * (i + 1));
            model_check("drain");
        end

`ifdef IFU_BOUND_CHECK_EN
        cycle(1'b1, 4 * ROMW, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("bound instr", out_instr, NOP);
        check("bound fault", {31'd0, fetch_fault}, 32'd1);
        model_check("bound");
        cycle(1'b1, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("inrange fault", {31'd0, fetch_fault}, 32'd0);
        check("inrange instr", out_instr, 32'h0);
        model_check("inrange");
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic        rv;
            logic [31:0] rp;
            logic        rd;
            rv = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       rp = $urandom;
                1:       rp = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                2:       rp = 4 * ROMW - 8 + $urandom_range(0, 15);
                default: rp = $urandom_range(0, 255);
            endcase
            rd = ($urandom_range(0, 3) != 0);
            cycle(rv, rp, rd);
            model_check("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
